// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined WIDTH-bit adder, one 16-bit carry-lookahead slice per
// stage with a registered inter-segment carry. Operands are skewed into the pipe
// and finished sum segments are deskewed so an operation leaves as a whole.
// Optional feature macro: CLA_PIPE_SUB_EN adds the sub port (a - b via ~b, carry ^ 1).
module cla_pipe_adder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef CLA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int SEGS = WIDTH / 16;

  // 4-wide lookahead: carries into positions 1..4 from generate/propagate and carry-in
  function automatic logic [3:0] look4(input logic [3:0] g, input logic [3:0] p,
                                       input logic c);
    logic [3:0] r;
    r[0] = g[0] | (p[0] & c);
    r[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    r[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    r[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c);
    return r;
  endfunction

  // 16-bit CLA slice: nibble group g/p, group-level carries, then bit carries per nibble
  function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] cb;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  nc;
    logic [3:0]  t;
    logic        cn;
    p = x ^ y;
    g = x & y;
    for (int j = 0; j < 4; j++) begin
      t     = look4(g[4*j +: 4], p[4*j +: 4], 1'b0);
      gg[j] = t[3];
      gp[j] = &p[4*j +: 4];
    end
    nc = look4(gg, gp, ci);
    cb = '0;
    for (int j = 0; j < 4; j++) begin
      cn = (j == 0) ? ci : nc[j-1];
      t  = look4(g[4*j +: 4], p[4*j +: 4], cn);
      cb[4*j]         = cn;
      cb[4*j+1 +: 3]  = t[2:0];
    end
    return {nc[3], p ^ cb};
  endfunction

  logic [SEGS-1:0]  vld_p;
  logic             en;
  logic [WIDTH-1:0] b_in;
  logic             c0;

  assign en        = ~vld_p[SEGS-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p[SEGS-1];

`ifdef CLA_PIPE_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c0   = c_in ^ sub;
`else
  assign b_in = b;
  assign c0   = c_in;
`endif

  // valid bits shift one stage per global advance
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (en) begin
      vld_p <= (vld_p << 1) | SEGS'(in_valid);
    end
  end

  for (genvar k = 0; k < SEGS; k++) begin : g_stage
    localparam int OPW = WIDTH - 16 * k;

    logic [OPW-1:0]        op_a;
    logic [OPW-1:0]        op_b;
    logic                  ci;
    logic [16:0]           res;
    logic [16*(k+1)-1:0]   sum_p;
    logic                  cy_p;

    assign res = cla16(op_a[15:0], op_b[15:0], ci);

    // ---- stage k: segment k add, registered carry toward stage k+1 ----
    if (k == 0) begin : g_first
      assign op_a = a;
      assign op_b = b_in;
      assign ci   = c0;

      // first finished sum segment
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_p <= '0;
        end else if (en) begin
          sum_p <= res[15:0];
        end
      end
    end else begin : g_next
      assign op_a = g_stage[k-1].g_skew.a_p;
      assign op_b = g_stage[k-1].g_skew.b_p;
      assign ci   = g_stage[k-1].cy_p;

      // deskew: append this segment above the already finished lower ones
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_p <= '0;
        end else if (en) begin
          sum_p <= {res[15:0], g_stage[k-1].sum_p};
        end
      end
    end

    // carry out of this slice
    always_ff @(posedge clk) begin
      if (rst) begin
        cy_p <= 1'b0;
      end else if (en) begin
        cy_p <= res[16];
      end
    end

    if (k < SEGS - 1) begin : g_skew
      logic [OPW-17:0] a_p;
      logic [OPW-17:0] b_p;

      // skew: carry the unconsumed upper operand segments forward
      always_ff @(posedge clk) begin
        if (rst) begin
          a_p <= '0;
          b_p <= '0;
        end else if (en) begin
          a_p <= op_a[OPW-1:16];
          b_p <= op_b[OPW-1:16];
        end
      end
    end
  end

  assign sum   = g_stage[SEGS-1].sum_p;
  assign c_out = g_stage[SEGS-1].cy_p;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder (WIDTH=64): directed and randomized operations checked
// against a plain-arithmetic reference model; also covers the sub path when
// CLA_PIPE_SUB_EN is defined.
module tb_cla_pipe_adder;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef CLA_PIPE_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .c_in(c_in),
`ifdef CLA_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .c_out(c_out)
  );

  // reference: exact (W+1)-bit result of a + b + c_in, or a + ~b + (c_in ^ 1) for subtract
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic s);
    logic [W-1:0] yy;
    yy = s ? ~y : y;
    return {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci ^ s};
  endfunction

  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s);
    a    = x;
    b    = y;
    c_in = ci;
`ifdef CLA_PIPE_SUB_EN
    sub  = s;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive_op('0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (sum !== '0) $display("FAIL reset_sum got=%h want=0", sum);
    else pass_cnt++;
    total_cnt++;
    if (c_out !== 1'b0) $display("FAIL reset_c_out got=%b want=0", c_out);
    else pass_cnt++;
  endtask

  // one isolated operation: out_valid must rise exactly 4 cycles after acceptance
  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s,
                        input logic [W-1:0] es, input logic ec);
    @(negedge clk);
    drive_op(x, y, ci, s);
    in_valid = 1'b1; out_ready = 1'b1; #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s_in_ready got=%b want=1", name, in_ready);
    else pass_cnt++;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      drive_op($urandom, $urandom, 1'b0, 1'b0);
      #1;
      total_cnt++;
      if (out_valid !== (i == 4))
        $display("FAIL %s_latency cycle=%0d got=%b want=%b", name, i, out_valid, i == 4);
      else pass_cnt++;
    end
    total_cnt++;
    if (sum !== es) $display("FAIL %s_sum got=%h want=%h", name, sum, es);
    else pass_cnt++;
    total_cnt++;
    if (c_out !== ec) $display("FAIL %s_c_out got=%b want=%b", name, c_out, ec);
    else pass_cnt++;
  endtask

  task automatic test_single_add();
    run_op("single_add", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0001_0000_0000_0000, 1'b0);
  endtask

  task automatic test_full_carry();
    run_op("full_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [W:0]   q[$];
    logic [W-1:0] xa, xb;
    logic         xc, xs;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid  = (sent < 8);
      xa = {$urandom, $urandom};
      xb = {$urandom, $urandom};
      xc = 1'($urandom);
`ifdef CLA_PIPE_SUB_EN
      xs = 1'($urandom);
`else
      xs = 1'b0;
`endif
      drive_op(xa, xb, xc, xs);
      #1;
      total_cnt++;
      if (in_ready !== !(out_valid && !out_ready))
        $display("FAIL stream_in_ready cyc=%0d got=%b want=%b", cyc, in_ready,
                 !(out_valid && !out_ready));
      else pass_cnt++;
      if (out_valid) begin
        total_cnt++;
        if (q.size() == 0) begin
          $display("FAIL stream_spurious cyc=%0d got=%b%h want=no output", cyc, c_out, sum);
        end else if ({c_out, sum} !== q[0]) begin
          $display("FAIL stream_result cyc=%0d got=%b_%h want=%b_%h", cyc, c_out, sum,
                   q[0][W], q[0][W-1:0]);
        end else begin
          pass_cnt++;
        end
        if (out_ready && q.size() != 0) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(xa, xb, xc, xs));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (got != 8) $display("FAIL stream_count got=%0d want=8", got);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    drive_op(64'd1, 64'd2, 1'b0, 1'b0);
    @(negedge clk);
    drive_op(64'd3, 64'd4, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rst = (i == 1 || i == 2);
      #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL midreset_out_valid step=%0d got=%b want=0", i, out_valid);
      else pass_cnt++;
      @(negedge clk);
    end
    rst = 1'b0;
    run_op("after_reset", 64'd5, 64'd7, 1'b0, 1'b0, 64'd12, 1'b0);
  endtask

  task automatic test_random_single();
    logic [W-1:0] xa, xb;
    logic         xc;
    logic [W:0]   e;
    for (int i = 0; i < 3; i++) begin
      xa = {$urandom, $urandom};
      xb = {$urandom, $urandom};
      xc = 1'($urandom);
      e  = model(xa, xb, xc, 1'b0);
      run_op("random_single", xa, xb, xc, 1'b0, e[W-1:0], e[W]);
    end
  endtask

`ifdef CLA_PIPE_SUB_EN
  task automatic test_sub();
    run_op("sub_neg", 64'd3, 64'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("sub_pos", 64'd5, 64'd3, 1'b0, 1'b1, 64'd2, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_full_carry();
    test_random_single();
    test_back_to_back();
    test_reset_midflight();
`ifdef CLA_PIPE_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
